// File: rtl/cordic_vectoring_iter.sv
// Iterative vectoring-mode CORDIC: one micro-rotation per clock turns (x0, y0) into
// a K-scaled magnitude and an atan2 angle, with full scale 2^width = 2*pi.
module cordic_vectoring_iter #(
    parameter int width      = 16,
    parameter int iterations = width + 2,
    parameter int guard_bits = iterations - 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [width-1:0] x0,
    input  logic signed [width-1:0] y0,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic        [width:0]   mag,
    output logic signed [width-1:0] z
);
    localparam int  xw = width + 2 + guard_bits;
    localparam int  zw = width + guard_bits;
    localparam int  cw = $clog2(iterations + 1);
    localparam real pi = 3.14159265358979323846;

    localparam logic signed [zw-1:0] half_pi = {2'b01, {(zw - 2){1'b0}}};
    localparam logic signed [xw-1:0] x_half  = xw'(1) <<< (guard_bits - 1);
    localparam logic signed [zw-1:0] z_half  = zw'(1) <<< (guard_bits - 1);

    // Elaboration-time atan(2^-k) in angle units, via the Taylor series (|t| <= 1/2).
    function automatic logic signed [zw-1:0] atan_entry(input int k);
        real    t, t2, term, sum, sgn, scaled;
        longint r;
        if (k == 0) begin
            sum = pi / 4.0;
        end else begin
            t = 1.0;
            for (int j = 0; j < k; j++) t = t / 2.0;
            t2   = t * t;
            term = t;
            sum  = 0.0;
            sgn  = 1.0;
            for (int n = 0; n < 40; n++) begin
                sum  = sum + sgn * term / real'(2 * n + 1);
                term = term * t2;
                sgn  = -sgn;
            end
        end
        scaled = sum / pi;
        for (int j = 0; j < width - 1 + guard_bits; j++) scaled = scaled * 2.0;
        scaled = scaled + 0.5;
        r = longint'(scaled);
        if (real'(r) > scaled) r = r - 1;
        return zw'(r);
    endfunction

    logic signed [zw-1:0] atan_table [iterations];

    for (genvar g = 0; g < iterations; g++) begin : g_atan
        localparam logic signed [zw-1:0] atan_val = atan_entry(g);
        assign atan_table[g] = atan_val;
    end

    typedef enum logic [1:0] {
        IDLE,
        ROTATE,
        DONE
    } state_t;

    state_t               state, state_next;
    logic [cw-1:0]        cnt;
    logic signed [xw-1:0] xr, yr;
    logic signed [zw-1:0] zr;
    logic                 zero_in;
    logic                 rotate_done;

    logic signed [xw-1:0] x_ext, y_ext, load_x, load_y, rot_x, rot_y, x_round;
    logic signed [zw-1:0] load_z, rot_z, z_round;

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign rotate_done = (cnt == cw'(iterations));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = ROTATE;
            ROTATE:  if (rotate_done) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Quadrant pre-rotation folds the left half-plane into |angle| <= pi/2.
    always_comb begin
        x_ext  = xw'(x0) <<< guard_bits;
        y_ext  = xw'(y0) <<< guard_bits;
        load_x = x_ext;
        load_y = y_ext;
        load_z = '0;
        if (x0[width-1]) begin
            if (!y0[width-1]) begin
                load_x = y_ext;
                load_y = -x_ext;
                load_z = half_pi;
            end else begin
                load_x = -y_ext;
                load_y = x_ext;
                load_z = -half_pi;
            end
        end
    end

    always_comb begin
        if (!yr[xw-1]) begin
            rot_x = xr + (yr >>> cnt);
            rot_y = yr - (xr >>> cnt);
            rot_z = zr + atan_table[cnt];
        end else begin
            rot_x = xr - (yr >>> cnt);
            rot_y = yr + (xr >>> cnt);
            rot_z = zr - atan_table[cnt];
        end
        x_round = xr + x_half;
        z_round = zr + z_half;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xr      <= '0;
            yr      <= '0;
            zr      <= '0;
            cnt     <= '0;
            zero_in <= 1'b0;
            mag     <= '0;
            z       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        xr      <= load_x;
                        yr      <= load_y;
                        zr      <= load_z;
                        cnt     <= '0;
                        zero_in <= (x0 == '0) && (y0 == '0);
                    end
                end
                ROTATE: begin
                    if (rotate_done) begin
                        mag <= (width + 1)'(x_round >>> guard_bits);
                        // A zero vector has no direction; report angle 0 instead of the atan sum.
                        z   <= zero_in ? '0 : width'(z_round >>> guard_bits);
                    end else begin
                        xr  <= rot_x;
                        yr  <= rot_y;
                        zr  <= rot_z;
                        cnt <= cnt + cw'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vectoring_iter.sv
// Self-checking bench for cordic_vectoring_iter: directed vector table, handshake
// corner sequences, and a random sweep against a real-valued atan2/magnitude model.
module tb_cordic_vectoring_iter;
    localparam real pi = 3.14159265358979323846;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] x0, y0;
    logic               out_valid;
    logic               out_ready;
    logic        [16:0] mag;
    logic signed [15:0] z;

    int checks = 0;
    int passes = 0;

    cordic_vectoring_iter #(.width(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x0       (x0),
        .y0       (y0),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .mag      (mag),
        .z        (z)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    typedef struct {
        int x;
        int y;
        int mag;
        int mag_tol;
        int ang;
        int ang_tol;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input bit ok, input longint act, input longint req);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    function automatic int ang_diff(input logic signed [15:0] a, input int b);
        logic signed [15:0] d;
        d = a - 16'(b);
        return (int'(d) < 0) ? -int'(d) : int'(d);
    endfunction

    task automatic start(input int xi, input int yi);
        @(negedge clk);
        x0       = 16'(xi);
        y0       = 16'(yi);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic check_result(input string tag, input int em, input int mt, input int ez, input int zt);
        int dm;
        dm = int'(mag) - em;
        if (dm < 0) dm = -dm;
        check({tag, " mag"}, dm <= mt, longint'(mag), em);
        check({tag, " z"}, ang_diff(z, ez) <= zt, longint'(z), ez);
    endtask

    initial begin
        int  lat;
        int  extra;
        bit  stable, ready_low;
        logic [16:0]        hold_mag;
        logic signed [15:0] hold_z;
        real kgain, p, em, ez, d;
        int  xi, yi;

        vecs[0] = '{32767, 0, 53959, 2, 0, 1};
        vecs[1] = '{0, 32767, 53959, 2, 16384, 1};
        vecs[2] = '{0, -32768, 53961, 2, -16384, 1};
        vecs[3] = '{-32767, 0, 53959, 2, -32768, 2};
        vecs[4] = '{-32768, -32768, 76312, 3, -24576, 1};
        vecs[5] = '{0, 0, 0, 0, 0, 0};
        vecs[6] = '{1000, 1000, 2329, 2, 8192, 1};
        vecs[7] = '{-20000, 15000, 41169, 2, 26056, 1};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x0        = '0;
        y0        = '0;
        #12;
        check("reset in_ready", in_ready == 1'b1, in_ready, 1);
        check("reset out_valid", out_valid == 1'b0, out_valid, 0);
        check("reset mag", mag == '0, mag, 0);
        check("reset z", z == '0, z, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            start(vecs[i].x, vecs[i].y);
            wait_result(lat);
            check($sformatf("vec%0d latency", i), lat == 19, lat, 19);
            check_result($sformatf("vec%0d", i), vecs[i].mag, vecs[i].mag_tol,
                         vecs[i].ang, vecs[i].ang_tol);
            release_result();
            check($sformatf("vec%0d in_ready after release", i), in_ready == 1'b1, in_ready, 1);
        end

        // Backpressure: DONE holds, new requests are ignored, exactly one result appears.
        start(32767, 0);
        wait_result(lat);
        check("bp latency", lat == 19, lat, 19);
        hold_mag  = mag;
        hold_z    = z;
        stable    = 1'b1;
        ready_low = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_valid = ~in_valid;
            x0       = 16'($urandom);
            y0       = 16'($urandom);
            @(negedge clk);
            if (in_ready) ready_low = 1'b0;
            if (!out_valid || mag != hold_mag || z != hold_z) stable = 1'b0;
        end
        check("bp in_ready low", ready_low, ready_low, 1);
        check("bp result stable", stable, stable, 1);
        check_result("bp", 53959, 2, 0, 1);
        in_valid = 1'b0;
        release_result();
        check("bp in_ready on release", in_ready == 1'b1, in_ready, 1);
        extra = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        check("bp single result", extra == 0, extra, 0);

        // Reset in the middle of a rotation discards the sample.
        start(32767, 0);
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort out_valid", out_valid == 1'b0, out_valid, 0);
        check("abort in_ready", in_ready == 1'b1, in_ready, 1);
        check("abort mag", mag == '0, mag, 0);
        @(negedge clk);
        reset = 1'b0;
        extra = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        check("abort no result", extra == 0, extra, 0);
        start(32767, 0);
        wait_result(lat);
        check("post-abort latency", lat == 19, lat, 19);
        check_result("post-abort", 53959, 2, 0, 1);
        release_result();

        // Random sweep against a real-valued model.
        kgain = 1.0;
        p     = 1.0;
        for (int i = 0; i < 18; i++) begin
            kgain = kgain * $sqrt(1.0 + p);
            p     = p / 4.0;
        end
        for (int n = 0; n < 512; n++) begin
            xi = int'($urandom_range(65535)) - 32768;
            yi = int'($urandom_range(65535)) - 32768;
            start(xi, yi);
            wait_result(lat);
            em = kgain * $sqrt(real'(xi) * real'(xi) + real'(yi) * real'(yi));
            ez = (xi == 0 && yi == 0) ? 0.0 : $atan2(real'(yi), real'(xi)) * 32768.0 / pi;
            d  = real'(mag) - em;
            if (d < 0.0) d = -d;
            check($sformatf("sweep%0d (%0d,%0d) mag", n, xi, yi), d <= 2.0,
                  longint'(mag), longint'($rtoi(em)));
            d = real'(z) - ez;
            while (d > 32768.0) d = d - 65536.0;
            while (d < -32768.0) d = d + 65536.0;
            if (d < 0.0) d = -d;
            check($sformatf("sweep%0d (%0d,%0d) z", n, xi, yi), d <= 2.0,
                  longint'(z), longint'($rtoi(ez)));
            release_result();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
